// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: MEM-stage request bus plus external data-memory bus of the data memory controller.
interface data_mem_ctrl_if;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_re;
    logic        ext_we;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata, ext_rdata, ext_ack,
        output mem_rdata, stall, err, ext_addr, ext_wdata, ext_re, ext_we
    );
    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata, ext_rdata, ext_ack,
        input  mem_rdata, stall, err, ext_addr, ext_wdata, ext_re, ext_we
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: IDLE/ACCESS/DONE bridge from the MEM stage to an acked external memory, with timeout abort.
module data_mem_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          op_we;
    logic          err_q;
    logic          req;
    assign req = bus.mem_re | bus.mem_we;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_we   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr_q  <= bus.mem_addr;
                    wdata_q <= bus.mem_wdata;
                    op_we   <= bus.mem_we;
                    cnt     <= '0;
                    // simultaneous read+write degrades to a write and flags the conflict
                    if (bus.mem_re & bus.mem_we) err_q <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: if (bus.ext_ack) begin
                    if (!op_we) rdata_q <= bus.ext_rdata;
                    state <= DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_q <= 1'b1;
                    if (!op_we) rdata_q <= ERR_DATA;
                    state <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.stall     = (state == IDLE && req) || state == ACCESS;
    assign bus.ext_re    = state == ACCESS && !op_we;
    assign bus.ext_we    = state == ACCESS && op_we;
    assign bus.ext_addr  = addr_q;
    assign bus.ext_wdata = wdata_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized scoreboard bench; the driver predicts each access, a monitor checks it at completion.
module tb_data_mem_ctrl;
    localparam int          TO = 16;
    localparam logic [31:0] ED = 32'hDEAD_BEEF;
    logic clk = 1'b0;
    logic rst = 1'b0;
    data_mem_ctrl_if bus();
    data_mem_ctrl #(.TIMEOUT(TO), .ERR_DATA(ED)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          res;
        int          wes;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: an access ends on the first stall-low cycle after stall-high cycles.
    initial begin
        int          st_n, re_n, we_n;
        logic [31:0] s_addr, s_wdata;
        logic        prev_stall, both;
        exp_t        e;
        st_n = 0; re_n = 0; we_n = 0; s_addr = '0; s_wdata = '0; prev_stall = 1'b0; both = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                st_n = 0; re_n = 0; we_n = 0; prev_stall = 1'b0; both = 1'b0;
            end else begin
                if (bus.stall) st_n++;
                if (bus.ext_re) re_n++;
                if (bus.ext_we) we_n++;
                if (bus.ext_re & bus.ext_we) both = 1'b1;
                if (bus.ext_re | bus.ext_we) begin
                    s_addr  = bus.ext_addr;
                    s_wdata = bus.ext_wdata;
                end
                if (prev_stall && !bus.stall) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("mem_rdata", bus.mem_rdata, e.rdata);
                        chk("err", 32'(bus.err), 32'(e.err));
                        chk("stall_cycles", st_n, e.stalls);
                        chk("re_cycles", re_n, e.res);
                        chk("we_cycles", we_n, e.wes);
                        chk("ext_addr", s_addr, e.addr);
                        chk("ext_wdata", s_wdata, e.wdata);
                        chk("both_strobes", 32'(both), 32'd0);
                    end
                    st_n = 0; re_n = 0; we_n = 0; both = 1'b0;
                end
                prev_stall = bus.stall;
            end
        end
    end

    // k = 1-based ACCESS cycle carrying the ack; 0 or beyond TO means no ack (timeout).
    task automatic do_txn(bit re, bit we, logic [31:0] addr, logic [31:0] wd, int k, logic [31:0] xd, bit hold);
        exp_t e;
        bit   to;
        int   acc;
        bit   done;
        done = 1'b0;
        to   = k < 1 || k > TO;
        acc  = to ? TO : k;
        if ((re && we) || to) m_err = 1'b1;
        if (re && !we) m_rdata = to ? ED : xd;
        e.rdata = m_rdata; e.err = m_err; e.stalls = acc + 1;
        e.res = (re && !we) ? acc : 0; e.wes = we ? acc : 0;
        e.addr = addr; e.wdata = wd;
        sb.push_back(e);
        bus.mem_re = re; bus.mem_we = we; bus.mem_addr = addr; bus.mem_wdata = wd;
        bus.ext_ack = 1'($urandom_range(0, 1)); bus.ext_rdata = $urandom;
        @(negedge clk);
        bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
        for (int c = 1; c <= TO + 3; c++) begin
            if (!bus.stall) begin
                done = 1'b1;
                break;
            end
            bus.ext_ack   = c == k;
            bus.ext_rdata = (c == k) ? xd : $urandom;
            @(negedge clk);
        end
        if (!done) begin
            bad++;
            $display("FAIL access_bound: stall still %b after %0d cycles, expected 0", bus.stall, TO + 3);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "controller stuck");
        end
        bus.ext_ack = 1'($urandom_range(0, 1)); bus.ext_rdata = $urandom;
        if (!hold) begin
            bus.mem_re = 1'b0; bus.mem_we = 1'b0;
        end
        @(negedge clk);
        bus.ext_ack = 1'($urandom_range(0, 1)); bus.ext_rdata = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r, k;
        bit  hold;
        bus.mem_re = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.ext_ack = 1'b0; bus.ext_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_ext_re", 32'(bus.ext_re), 32'd0);
        chk("rst_ext_we", 32'(bus.ext_we), 32'd0);
        chk("rst_ext_addr", bus.ext_addr, 32'd0);
        chk("rst_ext_wdata", bus.ext_wdata, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b1; mon_en = 1'b1;
        @(negedge clk);
        do_txn(1, 0, 32'h0000_1000, 32'h0, 1, 32'h1234_5678, 0);
        do_txn(0, 1, 32'h0000_0040, 32'hA5A5_A5A5, 3, 32'h0, 0);
        // reset in the middle of a read, ack arriving just after the reset edge
        mon_en = 1'b0;
        bus.mem_re = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h0000_2000; bus.ext_ack = 1'b0;
        @(negedge clk);
        bus.mem_re = 1'b0;
        chk("abort_pre_re", 32'(bus.ext_re), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; bus.ext_ack = 1'b1; bus.ext_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.ext_ack = 1'b0;
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_ext_re", 32'(bus.ext_re), 32'd0);
        chk("abort_ext_we", 32'(bus.ext_we), 32'd0);
        chk("abort_mem_rdata", bus.mem_rdata, 32'd0);
        chk("abort_err", 32'(bus.err), 32'd0);
        m_rdata = '0; m_err = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        do_txn(1, 0, 32'h0000_3000, 32'h0, 0, 32'h0, 0);
        do_txn(1, 0, 32'h0000_3004, 32'h0, 2, 32'h0BAD_C0DE, 0);
        do_txn(0, 1, 32'h0000_3008, 32'h1111_2222, TO, 32'h0, 0);
        do_txn(1, 1, 32'h0000_4000, 32'h5555_AAAA, 2, 32'h7777_7777, 0);
        for (int i = 0; i < 3; i++) do_txn(1, 0, 32'h0000_5000 + 32'(4 * i), 32'h0, 1, $urandom, i < 2);
        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 9);
            k    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
            hold = (i < 39) && ($urandom_range(0, 1) == 1);
            do_txn(r < 4 || r >= 8, r >= 4, $urandom, $urandom, k, $urandom, hold);
        end
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
